// File: rtl/cla_seq_adder_ctrl_pkg.sv
// Shared definitions for the sequential carry-lookahead adder controller.
// Contents:
//   SLICE_W - width of the shared carry-lookahead slice
//   state_e - controller FSM states
//   clog2   - ceiling log2, used to size the slice index register
package cla_seq_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/cla_seq_adder_ctrl_cla4.sv
// CLA_4BIT: 4-bit carry-lookahead adder slice (purely combinational).
// Ports:
//   a, b - 4-bit operands
//   cin  - carry in
//   sum  - 4-bit sum
//   cout - carry out
module CLA_4BIT (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c[3:0];
    cout = c[4];
  end

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// cla_seq_adder_ctrl: adds two WIDTH-bit operands through one shared 4-bit
// CLA slice, one nibble per clock, LSB first, with a registered carry.
// Optional subtraction is enabled by defining CLA_SEQ_SUB_EN (adds port sub).
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid/in_ready   - operand handshake (a, b, cin[, sub])
//   out_valid/out_ready - result handshake (sum, cout)
//   busy                - high while an operation is running or held
module cla_seq_adder_ctrl
  import cla_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned NSLICE = WIDTH / SLICE_W;
  localparam int unsigned IDX_W  = (clog2(NSLICE) > 1) ? clog2(NSLICE) : 1;

  if (((WIDTH % SLICE_W) != 0) || (WIDTH < SLICE_W)) begin : g_bad_width
    $error("cla_seq_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
  end

  state_e               state_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [WIDTH-1:0]     sum_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 carry_q;
  logic                 cout_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic                 busy_q;

  logic [SLICE_W-1:0]   slice_a;
  logic [SLICE_W-1:0]   slice_b;
  logic [SLICE_W-1:0]   slice_sum;
  logic                 slice_cout;
  logic                 last_slice;
  logic [WIDTH-1:0]     b_load;
  logic                 carry_load;

  // Operand mux: select the current nibble of each latched operand.
  always_comb begin
    slice_a    = a_q[idx_q*SLICE_W +: SLICE_W];
    slice_b    = b_q[idx_q*SLICE_W +: SLICE_W];
    last_slice = (idx_q == IDX_W'(NSLICE - 1));
  end

  // Subtraction is a + ~b + 1, so it only changes what gets latched at accept.
  always_comb begin
`ifdef CLA_SEQ_SUB_EN
    b_load     = sub ? ~b : b;
    carry_load = sub ? 1'b1 : cin;
`else
    b_load     = b;
    carry_load = cin;
`endif
  end

  CLA_4BIT u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b_load;
            carry_q    <= carry_load;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          sum_q[idx_q*SLICE_W +: SLICE_W] <= slice_sum;
          carry_q                         <= slice_cout;
          if (last_slice) begin
            cout_q      <= slice_cout;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Self-checking bench for cla_seq_adder_ctrl (WIDTH=16): table vectors,
// randomized operations against an arithmetic reference, and hand-written
// backpressure / mid-operation reset sequences.
module tb_cla_seq_adder_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
`ifdef CLA_SEQ_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int tests = 0;
  int fails = 0;

  cla_seq_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef CLA_SEQ_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required $finish)");
    $fatal(1);
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain (W+1)-bit addition.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    logic [W:0] r;
    r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    return r;
  endfunction

  // Waits for in_ready, performs one accept, scrambles the inputs afterwards,
  // and waits for out_valid. lat counts edges from accept to out_valid.
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                        output logic [W-1:0] s, output logic c, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
    a = xa; b = xb; cin = xc; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    check("in_ready_in_run", 32'(in_ready), 32'd0);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    s = sum;
    c = cout;
  endtask

  vec_t         vt[7];
  logic [W-1:0] s;
  logic         c;
  int           lat;
  logic [W-1:0] ra, rb;
  logic         rc;
  logic [W:0]   exp_r;
  logic         saw_valid;

  initial begin
    vt[0] = '{16'h0003, 16'h0001, 1'b0, 16'h0004, 1'b0};
    vt[1] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vt[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vt[3] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0};
    vt[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    vt[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vt[6] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'h0);
    check("rst_cout", 32'(cout), 32'd0);

    // Table vectors
    for (int i = 0; i < 7; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].cin, s, c, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      check($sformatf("vec%0d_sum", i), 32'(s), 32'(vt[i].s));
      check($sformatf("vec%0d_cout", i), 32'(c), 32'(vt[i].co));
      check($sformatf("vec%0d_busy_done", i), 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_in_ready_after", i), 32'(in_ready), 32'd1);
      check($sformatf("vec%0d_out_valid_after", i), 32'(out_valid), 32'd0);
    end

    // Backpressure: result held while out_ready=0, new in_valid ignored
    out_ready = 1'b0;
    run_op(16'hA5A5, 16'h5A5A, 1'b0, s, c, lat);
    check("bp_latency", 32'(lat), 32'd4);
    @(negedge clk);
    in_valid = 1'b1; a = 16'h0001; b = 16'h0001; cin = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_sum", 32'(sum), 32'hFFFF);
      check("bp_cout", 32'(cout), 32'd0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_busy", 32'(busy), 32'd0);
    check("bp_sum_kept", 32'(sum), 32'hFFFF);

    // Reset two cycles after accept
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_sum", 32'(sum), 32'h0);
    check("midrst_cout", 32'(cout), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) saw_valid = 1'b1;
    end
    check("midrst_no_out_valid", 32'(saw_valid), 32'd0);
    check("midrst_sum_after", 32'(sum), 32'h0);
    run_op(16'h0001, 16'h0001, 1'b0, s, c, lat);
    check("postrst_sum", 32'(s), 32'h0002);
    check("postrst_cout", 32'(c), 32'd0);
    check("postrst_latency", 32'(lat), 32'd4);

    // Randomized additions against the arithmetic reference
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      exp_r = ref_add(ra, rb, rc);
      run_op(ra, rb, rc, s, c, lat);
      check($sformatf("rand%0d_a%0h_b%0h_c%0d", i, ra, rb, rc), 32'({c, s}), 32'(exp_r));
      check($sformatf("rand%0d_latency", i), 32'(lat), 32'd4);
    end

`ifdef CLA_SEQ_SUB_EN
    // Subtraction: sum = a - b, cout = no borrow
    sub = 1'b1;
    run_op(16'h0005, 16'h0007, 1'b0, s, c, lat);
    check("sub_5_7_sum", 32'(s), 32'hFFFE);
    check("sub_5_7_cout", 32'(c), 32'd0);
    run_op(16'h0007, 16'h0005, 1'b1, s, c, lat);
    check("sub_7_5_sum", 32'(s), 32'h0002);
    check("sub_7_5_cout", 32'(c), 32'd1);
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = (i % 4 == 0) ? ra : W'($urandom);
      rc = 1'($urandom);
      run_op(ra, rb, rc, s, c, lat);
      check($sformatf("subrand%0d_sum", i), 32'(s), 32'(W'(ra - rb)));
      check($sformatf("subrand%0d_cout", i), 32'(c), 32'(ra >= rb));
    end
    sub = 1'b0;
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
